lsu_axi_master: RTL and testbench

//  Core-side AXI-Lite initiator for loads/stores; drives the data-memory slave over axi_intf.master.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/axi_intf.sv | 27 ++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu_axi_master.sv | 134 +++++++++++++
 tb/tb_lsu_axi_master.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, AXI response codes, FSM states
// and the latched request record.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} mem_size_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RESP} lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
  } lsu_req_t;
endpackage

// File: rtl/axi_intf.sv
// Single-beat AXI-Lite bundle, 32-bit address and data, with master/slave views.
interface axi_intf (input logic aclk);
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  modport master (
    input  aclk,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  aclk,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store replication + strobes + alignment check on the
// incoming request, and sign/zero extension of returned load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      st_off,
  input  logic [1:0]      st_size,
  input  logic [31:0]     st_data,
  output logic [3:0][7:0] st_lanes,
  output logic [3:0]      st_strb,
  output logic            misalign,
  input  logic [1:0]      ld_off,
  input  logic [1:0]      ld_size,
  input  logic            ld_uns,
  input  logic [31:0]     ld_rdata,
  output logic [31:0]     ld_data
);
  logic [31:0] ld_shift;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    // Narrow stores replicate the datum across the word so every lane carries it.
    assign st_lanes[i] = (st_size == SZ_B) ? st_data[7:0] :
                         (st_size == SZ_H) ? st_data[8*(i%2) +: 8] :
                                             st_data[8*i +: 8];
    assign st_strb[i]  = (st_size == SZ_B) ? (st_off == LANE) :
                         (st_size == SZ_H) ? (st_off[1] == LANE[1]) :
                                             (st_size == SZ_W);
  end

  assign misalign = (st_size == 2'b11) ||
                    ((st_size == SZ_H) && st_off[0]) ||
                    ((st_size == SZ_W) && (st_off != 2'b00));

  assign ld_shift = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_uns & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{~ld_uns & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end
endmodule

// File: rtl/lsu_axi_master.sv
// AXI-Lite initiator for single-beat core loads/stores; busy covers the whole transaction
// and done pulses once with err and the extended load result.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter bit USE_BRESP = 1'b1
) (
  axi_intf.master     axi,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        err
);
  logic clk;
  assign clk = axi.aclk;

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
  logic        err_q, err_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [3:0][7:0] st_lanes;
  logic [3:0]      st_strb;
  logic            misalign;
  logic [31:0]     ld_data;

  lsu_align u_align (
    .st_off   (req_addr[1:0]),
    .st_size  (req_size),
    .st_data  (req_wdata),
    .st_lanes (st_lanes),
    .st_strb  (st_strb),
    .misalign (misalign),
    .ld_off   (req_q.addr[1:0]),
    .ld_size  (req_q.size),
    .ld_uns   (req_q.uns),
    .ld_rdata (axi.rdata),
    .ld_data  (ld_data)
  );

  // Valids come straight from state so an async reset drops them in the same cycle.
  assign axi.awvalid = (state_q == WR) && !aw_ok_q;
  assign axi.wvalid  = (state_q == WR) && !w_ok_q;
  assign axi.bready  = (state_q == WR_B);
  assign axi.arvalid = (state_q == RD_A);
  assign axi.rready  = (state_q == RD_D);
  assign axi.awaddr  = req_q.addr;
  assign axi.araddr  = req_q.addr;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign err       = done && err_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: if (req_valid) begin
        req_d   = '{we: req_we, addr: req_addr, size: req_size, uns: req_unsigned};
        wdata_d = st_lanes;
        wstrb_d = st_strb;
        aw_ok_d = 1'b0;
        w_ok_d  = 1'b0;
        err_d   = misalign;
        if (misalign)    state_d = RESP;
        else if (req_we) state_d = WR;
        else             state_d = RD_A;
      end
      WR: begin
        aw_ok_d = aw_ok_q || (axi.awvalid && axi.awready);
        w_ok_d  = w_ok_q  || (axi.wvalid  && axi.wready);
        if (aw_ok_d && w_ok_d) begin
          if (USE_BRESP) state_d = WR_B;
          else           state_d = RESP;
        end
      end
      WR_B: if (axi.bvalid) begin
        err_d   = (axi.bresp != AXI_RESP_OKAY);
        state_d = RESP;
      end
      RD_A: if (axi.arready) state_d = RD_D;
      RD_D: if (axi.rvalid) begin
        rd_data_d = ld_data;
        err_d     = (axi.rresp != AXI_RESP_OKAY);
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_lsu_axi_master.sv
module tb_lsu_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid0, req_valid1, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        ready0, busy0, done0, err0, ready1, busy1, done1, err1;
  logic [31:0] rd0, rd1;

  logic        aw_rdy, w_rdy, ar_rdy, r_vld, r_ovr_en;
  logic [31:0] r_ovr;
  logic [31:0] mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_intf ax0 (.aclk(clk));
  axi_intf ax1 (.aclk(clk));

  assign ax0.awready = aw_rdy;
  assign ax0.wready  = w_rdy;
  assign ax0.bvalid  = 1'b1;
  assign ax0.bresp   = 2'b00;
  assign ax0.arready = ar_rdy;
  assign ax0.rvalid  = r_vld;
  assign ax0.rresp   = 2'b00;
  assign ax0.rdata   = r_ovr_en ? r_ovr : mem[ax0.araddr[5:2]];

  assign ax1.awready = 1'b1;
  assign ax1.wready  = 1'b1;
  assign ax1.bvalid  = 1'b1;
  assign ax1.bresp   = 2'b10;
  assign ax1.arready = 1'b0;
  assign ax1.rvalid  = 1'b0;
  assign ax1.rresp   = 2'b00;
  assign ax1.rdata   = 32'h0;

  always @(posedge clk)
    if (ax0.wvalid && ax0.wready)
      for (int i = 0; i < 4; i++)
        if (ax0.wstrb[i]) mem[ax0.awaddr[5:2]][8*i +: 8] <= ax0.wdata[8*i +: 8];

  lsu_axi_master #(.USE_BRESP(1'b0)) u0 (
    .axi(ax0), .rst(rst), .req_valid(req_valid0), .req_ready(ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .busy(busy0), .done(done0), .rd_data(rd0), .err(err0)
  );

  lsu_axi_master #(.USE_BRESP(1'b1)) u1 (
    .axi(ax1), .rst(rst), .req_valid(req_valid1), .req_ready(ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .busy(busy1), .done(done1), .rd_data(rd1), .err(err1)
  );

  task automatic report(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input bit sel, input bit we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input bit uns);
    req_we = we; req_addr = addr; req_wdata = data; req_size = size; req_unsigned = uns;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; r_vld = 1'b1; r_ovr_en = 1'b0; r_ovr = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (ready0 !== 1'b1) report("rst_ready", ready0, 1'b1);
    n_chk++; if (busy0 !== 1'b0) report("rst_busy", busy0, 1'b0);
    n_chk++; if (done0 !== 1'b0) report("rst_done", done0, 1'b0);
    n_chk++; if (err0 !== 1'b0) report("rst_err", err0, 1'b0);
    n_chk++; if (rd0 !== 32'h0) report("rst_rd", rd0, 32'h0);
    n_chk++; if (ax0.awvalid !== 1'b0) report("rst_awvalid", ax0.awvalid, 1'b0);
    n_chk++; if (ax0.arvalid !== 1'b0) report("rst_arvalid", ax0.arvalid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0);
    n_chk++; if (ax0.awvalid !== 1'b1) report("t1_awvalid", ax0.awvalid, 1'b1);
    n_chk++; if (ax0.wvalid !== 1'b1) report("t1_wvalid", ax0.wvalid, 1'b1);
    n_chk++; if (ax0.awaddr !== 32'h10) report("t1_awaddr", ax0.awaddr, 32'h10);
    n_chk++; if (ax0.wstrb !== 4'b1111) report("t1_wstrb", ax0.wstrb, 4'b1111);
    n_chk++; if (ax0.wdata !== 32'hDEADBEEF) report("t1_wdata", ax0.wdata, 32'hDEADBEEF);
    n_chk++; if (busy0 !== 1'b1) report("t1_busy", busy0, 1'b1);
    n_chk++; if (done0 !== 1'b0) report("t1_done_c1", done0, 1'b0);
    @(negedge clk);
    n_chk++; if (done0 !== 1'b1) report("t1_done_c2", done0, 1'b1);
    n_chk++; if (err0 !== 1'b0) report("t1_err", err0, 1'b0);
    @(negedge clk);
    n_chk++; if (done0 !== 1'b0) report("t1_done_c3", done0, 1'b0);
    n_chk++; if (ready0 !== 1'b1) report("t1_ready_c3", ready0, 1'b1);

    issue(0, 1, 32'h13, 32'h000000A5, 2'b00, 0);
    n_chk++; if (ax0.wstrb !== 4'b1000) report("t2_wstrb", ax0.wstrb, 4'b1000);
    n_chk++; if (ax0.wdata !== 32'hA5A5A5A5) report("t2_wdata", ax0.wdata, 32'hA5A5A5A5);
    @(negedge clk);
    n_chk++; if (done0 !== 1'b1) report("t2_done", done0, 1'b1);
    @(negedge clk);
    issue(0, 0, 32'h10, 32'h0, 2'b10, 0);
    n_chk++; if (ax0.arvalid !== 1'b1) report("t2_arvalid_c1", ax0.arvalid, 1'b1);
    n_chk++; if (ax0.araddr !== 32'h10) report("t2_araddr", ax0.araddr, 32'h10);
    n_chk++; if (ax0.rready !== 1'b0) report("t2_rready_c1", ax0.rready, 1'b0);
    @(negedge clk);
    n_chk++; if (ax0.arvalid !== 1'b0) report("t2_arvalid_c2", ax0.arvalid, 1'b0);
    n_chk++; if (ax0.rready !== 1'b1) report("t2_rready_c2", ax0.rready, 1'b1);
    n_chk++; if (done0 !== 1'b0) report("t2_done_c2", done0, 1'b0);
    @(negedge clk);
    n_chk++; if (done0 !== 1'b1) report("t2_done_c3", done0, 1'b1);
    n_chk++; if (rd0 !== 32'hA5ADBEEF) report("t2_rd", rd0, 32'hA5ADBEEF);
    n_chk++; if (err0 !== 1'b0) report("t2_err", err0, 1'b0);
    @(negedge clk);

    r_ovr_en = 1'b1; r_ovr = 32'h80011234;
    issue(0, 0, 32'h12, 32'h0, 2'b01, 0);
    repeat (2) @(negedge clk);
    n_chk++; if (done0 !== 1'b1) report("t3_lh_done", done0, 1'b1);
    n_chk++; if (rd0 !== 32'hFFFF8001) report("t3_lh", rd0, 32'hFFFF8001);
    @(negedge clk);
    issue(0, 0, 32'h12, 32'h0, 2'b01, 1);
    repeat (2) @(negedge clk);
    n_chk++; if (rd0 !== 32'h00008001) report("t3_lhu", rd0, 32'h00008001);
    @(negedge clk);
    issue(0, 0, 32'h11, 32'h0, 2'b00, 1);
    repeat (2) @(negedge clk);
    n_chk++; if (rd0 !== 32'h00000012) report("t3_lbu", rd0, 32'h00000012);
    @(negedge clk);
    issue(0, 0, 32'h13, 32'h0, 2'b00, 0);
    repeat (2) @(negedge clk);
    n_chk++; if (rd0 !== 32'hFFFFFF80) report("t3_lb", rd0, 32'hFFFFFF80);
    @(negedge clk);
    r_ovr_en = 1'b0;

    w_rdy = 1'b0;
    issue(0, 1, 32'h20, 32'h12345678, 2'b10, 0);
    n_chk++; if (ax0.awvalid !== 1'b1) report("t4_awvalid_c1", ax0.awvalid, 1'b1);
    n_chk++; if (ax0.wvalid !== 1'b1) report("t4_wvalid_c1", ax0.wvalid, 1'b1);
    @(negedge clk);
    n_chk++; if (ax0.awvalid !== 1'b0) report("t4_awvalid_c2", ax0.awvalid, 1'b0);
    n_chk++; if (ax0.wvalid !== 1'b1) report("t4_wvalid_c2", ax0.wvalid, 1'b1);
    n_chk++; if (done0 !== 1'b0) report("t4_done_c2", done0, 1'b0);
    @(negedge clk);
    n_chk++; if (ax0.wvalid !== 1'b1) report("t4_wvalid_c3", ax0.wvalid, 1'b1);
    n_chk++; if (ax0.wdata !== 32'h12345678) report("t4_wdata_c3", ax0.wdata, 32'h12345678);
    n_chk++; if (done0 !== 1'b0) report("t4_done_c3", done0, 1'b0);
    @(negedge clk);
    n_chk++; if (ax0.wvalid !== 1'b1) report("t4_wvalid_c4", ax0.wvalid, 1'b1);
    n_chk++; if (ax0.wdata !== 32'h12345678) report("t4_wdata_c4", ax0.wdata, 32'h12345678);
    n_chk++; if (ax0.wstrb !== 4'b1111) report("t4_wstrb_c4", ax0.wstrb, 4'b1111);
    n_chk++; if (done0 !== 1'b0) report("t4_done_c4", done0, 1'b0);
    w_rdy = 1'b1;
    @(negedge clk);
    n_chk++; if (done0 !== 1'b1) report("t4_done_c5", done0, 1'b1);
    n_chk++; if (ax0.wvalid !== 1'b0) report("t4_wvalid_c5", ax0.wvalid, 1'b0);
    @(negedge clk);
    n_chk++; if (done0 !== 1'b0) report("t4_done_c6", done0, 1'b0);

    issue(0, 0, 32'h06, 32'h0, 2'b10, 0);
    n_chk++; if (ax0.arvalid !== 1'b0) report("t5_arvalid", ax0.arvalid, 1'b0);
    n_chk++; if (done0 !== 1'b1) report("t5_done", done0, 1'b1);
    n_chk++; if (err0 !== 1'b1) report("t5_err", err0, 1'b1);
    n_chk++; if (rd0 !== 32'hFFFFFF80) report("t5_rd_held", rd0, 32'hFFFFFF80);
    @(negedge clk);
    n_chk++; if (done0 !== 1'b0) report("t5_done_c2", done0, 1'b0);
    n_chk++; if (ready0 !== 1'b1) report("t5_ready_c2", ready0, 1'b1);
    issue(0, 1, 32'h10, 32'h0, 2'b11, 0);
    n_chk++; if (ax0.awvalid !== 1'b0) report("t5_sz11_awvalid", ax0.awvalid, 1'b0);
    n_chk++; if (err0 !== 1'b1) report("t5_sz11_err", err0, 1'b1);
    @(negedge clk);

    issue(1, 1, 32'h30, 32'h1, 2'b10, 0);
    n_chk++; if (ax1.awvalid !== 1'b1) report("t5b_awvalid", ax1.awvalid, 1'b1);
    @(negedge clk);
    n_chk++; if (ax1.bready !== 1'b1) report("t5b_bready", ax1.bready, 1'b1);
    n_chk++; if (done1 !== 1'b0) report("t5b_done_c2", done1, 1'b0);
    @(negedge clk);
    n_chk++; if (done1 !== 1'b1) report("t5b_done_c3", done1, 1'b1);
    n_chk++; if (err1 !== 1'b1) report("t5b_err", err1, 1'b1);
    @(negedge clk);

    r_vld = 1'b0;
    issue(0, 0, 32'h10, 32'h0, 2'b10, 0);
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (ax0.rready !== 1'b1) report("t6_rready_pre", ax0.rready, 1'b1);
    rst = 1'b1;
    #1;
    n_chk++; if (ax0.rready !== 1'b0) report("t6_rready_rst", ax0.rready, 1'b0);
    n_chk++; if (ax0.arvalid !== 1'b0) report("t6_arvalid_rst", ax0.arvalid, 1'b0);
    n_chk++; if (busy0 !== 1'b0) report("t6_busy_rst", busy0, 1'b0);
    n_chk++; if (done0 !== 1'b0) report("t6_done_rst", done0, 1'b0);
    @(negedge clk);
    rst = 1'b0; r_vld = 1'b1;
    @(negedge clk);
    n_chk++; if (done0 !== 1'b0) report("t6_done_after", done0, 1'b0);
    n_chk++; if (ready0 !== 1'b1) report("t6_ready_after", ready0, 1'b1);
    issue(0, 0, 32'h10, 32'h0, 2'b10, 0);
    n_chk++; if (ax0.arvalid !== 1'b1) report("t6_arvalid_new", ax0.arvalid, 1'b1);
    repeat (2) @(negedge clk);
    n_chk++; if (done0 !== 1'b1) report("t6_done_new", done0, 1'b1);
    n_chk++; if (rd0 !== 32'hA5ADBEEF) report("t6_rd_new", rd0, 32'hA5ADBEEF);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
